// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: synchronises and debounces the start/stop, clear and direction buttons,
// and sequences the BCD stopwatch's enable/up/clear inputs, stopping at terminal count.
module stopwatch_ctrl #(
    parameter int DB_CYCLES  = 1000000,
    parameter int DB_W       = 20,
    parameter int CLR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_ss,
    input  logic        btn_clr,
    input  logic        btn_dir,
    input  logic [15:0] digits,
    output logic        sw_enable,
    output logic        sw_up,
    output logic        sw_clear,
    output logic        done,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {CLEAR = 3'd0, IDLE = 3'd1, RUN = 3'd2, PAUSE = 3'd3, DONE = 3'd4} state_t;
    localparam int CW = $clog2(CLR_CYCLES + 1);

    // bit 0 = clear, bit 1 = start/stop, bit 2 = direction
    logic [2:0]      raw, s1, s2, db, db_q, ev;
    logic [DB_W-1:0] cnt [3];
    state_t          st, st_d;
    logic            up_d, ev_clr, ev_ss, ev_dir, term;
    logic [CW-1:0]   ccnt;

    assign raw = {btn_dir, btn_ss, btn_clr};
    assign ev  = db & ~db_q;
    assign state = st;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db;
            for (int k = 0; k < 3; k++) begin
                if (s2[k] == db[k]) cnt[k] <= '0;
                else if (cnt[k] == DB_W'(DB_CYCLES - 1)) begin
                    cnt[k] <= '0;
                    db[k]  <= s2[k];
                end else cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    always_comb begin
        ev_clr = ev[0];
        ev_ss  = ev[1] & ~ev[0];
        ev_dir = ev[2] & ~ev[1] & ~ev[0];
        term   = sw_up ? (digits == 16'h9999) : (digits == 16'h0000);
        st_d   = st;
        up_d   = sw_up;
        if (ev_clr) st_d = CLEAR;
        else case (st)
            CLEAR:       st_d = (ccnt == CW'(CLR_CYCLES - 1)) ? IDLE : CLEAR;
            IDLE, PAUSE: begin
                st_d = ev_ss ? RUN : st;
                up_d = ev_dir ? ~sw_up : sw_up;
            end
            RUN:         st_d = term ? DONE : (ev_ss ? PAUSE : RUN);
            DONE:        st_d = DONE;
            default:     st_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= CLEAR;
            ccnt      <= '0;
            sw_up     <= 1'b1;
            sw_enable <= 1'b0;
            sw_clear  <= 1'b1;
            done      <= 1'b0;
        end else begin
            st        <= st_d;
            sw_up     <= up_d;
            ccnt      <= (st == CLEAR && !ev_clr) ? ccnt + 1'b1 : '0;
            sw_enable <= (st_d == RUN);
            sw_clear  <= (st_d == CLEAR);
            done      <= (st_d == DONE);
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and randomized button stimulus around a behavioural stopwatch,
// compared every cycle against a window-based debounce and rule-level sequencer model.
module tb_stopwatch_ctrl;
    localparam int DB = 4, CLR = 2;
    logic        clk = 0, reset_n = 0, btn_ss = 0, btn_clr = 0, btn_dir = 0;
    logic [15:0] digits;
    logic        sw_enable, sw_up, sw_clear, done;
    logic [2:0]  state;
    int vectors = 0, miscompares = 0;
    int m_state, m_left;
    bit m_up;
    bit m_db[3], m_ev[3];
    bit hist[3][$];
    int sw_cnt = 0, sw_tick = 0, force9 = 0;
    int hold[3];

    stopwatch_ctrl #(.DB_CYCLES(DB), .DB_W(4), .CLR_CYCLES(CLR)) dut (
        .clk(clk), .reset_n(reset_n), .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_dir(btn_dir),
        .digits(digits), .sw_enable(sw_enable), .sw_up(sw_up), .sw_clear(sw_clear),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    assign digits = to_bcd(force9 != 0 ? 9999 : sw_cnt);

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_left  = CLR;
        m_up    = 1;
        for (int b = 0; b < 3; b++) begin
            m_db[b] = 0;
            m_ev[b] = 0;
            hist[b] = {};
            repeat (DB + 2) hist[b].push_back(1'b0);
        end
    endtask

    // One clock edge of the reference: the sequencer acts on last cycle's events,
    // then the debouncer looks at the raw samples that reach it through the synchroniser.
    task automatic model_step(int dv);
        bit evc, evs, evd, term, all_diff;
        bit rb[3];
        evc  = m_ev[0];
        evs  = m_ev[1] && !evc;
        evd  = m_ev[2] && !evc && !m_ev[1];
        term = m_up ? (dv == 9999) : (dv == 0);
        if (evc) begin
            m_state = 0;
            m_left  = CLR;
        end else case (m_state)
            0: begin
                m_left--;
                if (m_left == 0) m_state = 1;
            end
            1, 3: begin
                if (evs) m_state = 2;
                else if (evd) m_up = !m_up;
            end
            2: if (term) m_state = 4; else if (evs) m_state = 3;
            default: ;
        endcase
        rb[0] = btn_clr; rb[1] = btn_ss; rb[2] = btn_dir;
        for (int b = 0; b < 3; b++) begin
            hist[b].push_back(rb[b]);
            void'(hist[b].pop_front());
            all_diff = 1;
            for (int j = 0; j < DB; j++) if (hist[b][j] == m_db[b]) all_diff = 0;
            m_ev[b] = all_diff && !m_db[b];
            if (all_diff) m_db[b] = !m_db[b];
        end
    endtask

    function automatic logic [6:0] exp_outs();
        return {3'(m_state), m_state == 2, m_up, m_state == 0, m_state == 4};
    endfunction

    task automatic cycle(int n = 1);
        repeat (n) begin
            bit en, cl, up;
            int dv;
            en = (m_state == 2);
            cl = (m_state == 0);
            up = m_up;
            dv = force9 != 0 ? 9999 : sw_cnt;
            @(posedge clk);
            #1;
            if (!reset_n) model_reset(); else model_step(dv);
            check("outs", {state, sw_enable, sw_up, sw_clear, done}, exp_outs());
            if (cl) begin
                sw_cnt  = 0;
                sw_tick = 0;
            end else if (en) begin
                if (sw_tick == 9) begin
                    sw_tick = 0;
                    sw_cnt  = up ? (sw_cnt + 1) % 10000 : (sw_cnt + 9999) % 10000;
                end else sw_tick++;
            end
        end
    endtask

    task automatic set_btn(int b, logic v);
        if (b == 0) btn_clr = v;
        else if (b == 1) btn_ss = v;
        else btn_dir = v;
    endtask

    task automatic press(int b, int len);
        set_btn(b, 1'b1);
        cycle(len);
        set_btn(b, 1'b0);
        cycle(DB + 4);
    endtask

    initial begin
        model_reset();
        cycle(2);
        check("rst_outs", {state, sw_enable, sw_up, sw_clear, done}, 7'b000_0_1_1_0);
        reset_n = 1;
        cycle(1);
        check("clr_hold", sw_clear, 1);
        cycle(1);
        check("idle_state", state, 1);
        check("idle_outs", {sw_enable, sw_up, sw_clear}, 3'b010);
        // short press is rejected, long press starts the count 7 cycles after the press
        btn_ss = 1; cycle(3); btn_ss = 0; cycle(10);
        check("short_press", state, 1);
        btn_ss = 1; cycle(6);
        check("en_early", sw_enable, 0);
        cycle(1);
        check("en_at_7", sw_enable, 1);
        check("run_state", state, 2);
        cycle(5); btn_ss = 0; cycle(40);
        press(1, 8);
        check("pause", {state, sw_enable}, {3'd3, 1'b0});
        press(2, 8);
        check("dir_pause", sw_up, 0);
        press(1, 8);
        check("resume", state, 2);
        press(2, 8);
        check("dir_run_ign", {state, sw_up}, {3'd2, 1'b0});
        // terminal count with up direction
        press(1, 8);
        press(2, 8);
        press(1, 8);
        check("run_up", {state, sw_up}, {3'd2, 1'b1});
        force9 = 1;
        cycle(1);
        check("term_done", {state, sw_enable, done}, {3'd4, 1'b0, 1'b1});
        press(1, 8);
        check("done_ss_ign", state, 4);
        force9 = 0;
        btn_clr = 1; cycle(7);
        check("done_clr", {state, sw_clear}, {3'd0, 1'b1});
        cycle(1);
        check("clr_2nd", state, 0);
        cycle(1);
        check("clr_idle", state, 1);
        btn_clr = 0; cycle(DB + 4);
        // simultaneous clear and start/stop while running
        press(1, 8);
        btn_clr = 1; btn_ss = 1; cycle(7);
        check("clr_over_ss", {state, sw_clear}, {3'd0, 1'b1});
        cycle(1);
        check("clr_over_ss2", state, 0);
        cycle(1);
        check("clr_over_ss_idle", state, 1);
        btn_clr = 0; btn_ss = 0; cycle(DB + 4);
        // random button activity with bounces and occasional forced terminal value
        for (int b = 0; b < 3; b++) hold[b] = $urandom_range(1, 14);
        repeat (3000) begin
            for (int b = 0; b < 3; b++) begin
                hold[b]--;
                if (hold[b] == 0) begin
                    hold[b] = $urandom_range(1, 14);
                    set_btn(b, (b == 0) ? btn_clr ^ 1'b1 : (b == 1) ? btn_ss ^ 1'b1 : btn_dir ^ 1'b1);
                end
            end
            if ($urandom_range(0, 199) == 0) force9 = force9 != 0 ? 0 : 1;
            cycle(1);
        end
        // asynchronous reset in the middle of a run
        btn_clr = 0; btn_ss = 0; btn_dir = 0; force9 = 0;
        cycle(DB + 4);
        press(0, 8);
        if (!m_up) press(2, 8);
        press(1, 8);
        check("pre_async_run", state, 2);
        cycle(1);
        #2 reset_n = 0;
        #1;
        check("async_rst", {state, sw_enable, sw_clear, done}, {3'd0, 1'b0, 1'b1, 1'b0});
        model_reset();
        cycle(2);
        reset_n = 1;
        cycle(2);
        check("post_rst_idle", state, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
